brick_damage_writer: RTL and testbench

BRICK_DAMAGE_WRITER -- requirements
Module: brick_damage_writer

---
 rtl/brick_pkg.sv | 17 +
 rtl/brick_damage_writer.sv | 116 +++++++++++
 tb/tb_brick_damage_writer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/brick_pkg.sv
// Shared types and default sizes for the brick damage writer.
package brick_pkg;

  localparam int unsigned DefNumBricks = 40;
  localparam int unsigned DefHealthW   = 3;
  localparam int unsigned DefAddrW     = 6;

  typedef enum logic [2:0] {
    StIdle,
    StInitRd,
    StInitWr,
    StReady,
    StHitRd,
    StHitWr
  } brick_state_e;

endpackage

// File: rtl/brick_damage_writer.sv
// Loads brick health from the level ROM into the health RAM, then applies one point of
// damage per accepted hit with a read-modify-write.
module brick_damage_writer
  import brick_pkg::*;
#(
  parameter int unsigned NUM_BRICKS = DefNumBricks,
  parameter int unsigned HEALTH_W   = DefHealthW,
  parameter int unsigned ADDR_W     = DefAddrW
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                level_start,
  output logic [ADDR_W-1:0]   level_addr,
  input  logic [HEALTH_W-1:0] level_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [HEALTH_W-1:0] mem_rdata,
  output logic [HEALTH_W-1:0] mem_wdata,
  output logic                mem_we,
  input  logic                hit_valid,
  input  logic [ADDR_W-1:0]   hit_idx,
  output logic                hit_ready,
  output logic                game_write,
  output logic                brick_destroyed,
  output logic [9:0]          total_health,
  output logic                init_done
);

  brick_state_e        state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [ADDR_W-1:0]   hit_q;
  logic [9:0]          total_q;
  logic                init_done_q;
  logic [10:0]         health_sum;
  logic                hit_in_range;
  logic                start_ok;

  always_comb begin
    health_sum   = {1'b0, total_q} + 11'(level_rdata);
    hit_in_range = 32'(hit_idx) < NUM_BRICKS;
    start_ok     = level_start && (state_q == StIdle || state_q == StReady);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      hit_q       <= '0;
      total_q     <= '0;
      init_done_q <= 1'b0;
    end else if (start_ok) begin
      state_q     <= StInitRd;
      idx_q       <= '0;
      total_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle:   state_q <= StIdle;
        StInitRd: state_q <= StInitWr;
        StInitWr: begin
          total_q <= health_sum[10] ? 10'd1023 : health_sum[9:0];
          if (idx_q == ADDR_W'(NUM_BRICKS - 1)) begin
            state_q     <= StReady;
            init_done_q <= 1'b1;
          end else begin
            idx_q   <= idx_q + ADDR_W'(1);
            state_q <= StInitRd;
          end
        end
        StReady: begin
          // Out-of-range hits are consumed but never reach the RAM.
          if (hit_valid && hit_in_range) begin
            hit_q   <= hit_idx;
            state_q <= StHitRd;
          end
        end
        StHitRd:  state_q <= StHitWr;
        StHitWr:  state_q <= StReady;
        default:  state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    level_addr      = '0;
    mem_addr        = '0;
    mem_wdata       = '0;
    mem_we          = 1'b0;
    game_write      = 1'b0;
    brick_destroyed = 1'b0;
    hit_ready       = (state_q == StReady) && !level_start;
    unique case (state_q)
      StInitRd: level_addr = idx_q;
      StInitWr: begin
        mem_we    = 1'b1;
        mem_addr  = idx_q;
        mem_wdata = level_rdata;
      end
      StHitRd: mem_addr = hit_q;
      StHitWr: begin
        mem_addr = hit_q;
        // A brick already at zero health takes no further damage.
        if (mem_rdata != '0) begin
          mem_we          = 1'b1;
          mem_wdata       = mem_rdata - HEALTH_W'(1);
          game_write      = 1'b1;
          brick_destroyed = (mem_rdata == HEALTH_W'(1));
        end
      end
      default: ;
    endcase
  end

  assign total_health = total_q;
  assign init_done    = init_done_q;

endmodule

// File: tb/tb_brick_damage_writer.sv
// Directed bench: per-cycle vector table for load and hits, then a mid-load reset and reload.
module tb_brick_damage_writer;

  localparam int unsigned NB = 4;
  localparam int unsigned HW = 3;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          level_start = 1'b0;
  logic [AW-1:0] level_addr;
  logic [HW-1:0] level_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic [HW-1:0] mem_rdata = '0;
  logic [HW-1:0] mem_wdata;
  logic          mem_we;
  logic          hit_valid = 1'b0;
  logic [AW-1:0] hit_idx = '0;
  logic          hit_ready;
  logic          game_write;
  logic          brick_destroyed;
  logic [9:0]    total_health;
  logic          init_done;

  brick_damage_writer #(
    .NUM_BRICKS(NB),
    .HEALTH_W  (HW),
    .ADDR_W    (AW)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .level_start    (level_start),
    .level_addr     (level_addr),
    .level_rdata    (level_rdata),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .hit_valid      (hit_valid),
    .hit_idx        (hit_idx),
    .hit_ready      (hit_ready),
    .game_write     (game_write),
    .brick_destroyed(brick_destroyed),
    .total_health   (total_health),
    .init_done      (init_done)
  );

  always #5 clk = ~clk;

  logic [HW-1:0] rom [8];
  logic [HW-1:0] ram [8];
  int wr_cnt = 0;
  int gw_cnt = 0;

  // Synchronous ROM and RAM models with one-cycle read latency.
  always @(posedge clk) begin
    level_rdata <= rom[level_addr];
    mem_rdata   <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (resetn && mem_we) wr_cnt <= wr_cnt + 1;
    if (resetn && game_write) gw_cnt <= gw_cnt + 1;
  end

  typedef struct {
    logic          start;
    logic          hv;
    logic [AW-1:0] hidx;
    logic          we;
    logic [AW-1:0] addr;
    logic          acare;
    logic [HW-1:0] wdata;
    logic          gw;
    logic          bd;
    logic          hr;
    logic          done;
    logic [9:0]    tot;
    logic [AW-1:0] laddr;
  } vec_t;

  vec_t vecs [22];
  int n_tests = 0;
  int n_fail = 0;

  function automatic vec_t mk(logic st, logic hv, int hidx, logic we, int addr, logic ac,
                              int wd, logic gw, logic bd, logic hr, logic dn, int tot, int la);
    vec_t v;
    v.start = st;      v.hv = hv;         v.hidx = AW'(hidx);
    v.we = we;         v.addr = AW'(addr); v.acare = ac;
    v.wdata = HW'(wd); v.gw = gw;         v.bd = bd;
    v.hr = hr;         v.done = dn;       v.tot = 10'(tot);
    v.laddr = AW'(la);
    return v;
  endfunction

  task automatic check(string name, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    rom[0] = 3; rom[1] = 0; rom[2] = 1; rom[3] = 2;
    for (int i = 4; i < 8; i++) rom[i] = 0;
    for (int i = 0; i < 8; i++) ram[i] = 0;

    //              st hv idx we ad ac wd gw bd hr dn tot la
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 1, 0, 1, 3, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1);
    vecs[4]  = mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 3, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2);
    vecs[6]  = mk(0, 0, 0, 1, 2, 1, 1, 0, 0, 0, 0, 3, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 3);
    vecs[8]  = mk(0, 0, 0, 1, 3, 1, 2, 0, 0, 0, 0, 4, 0);
    vecs[9]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 6, 0);
    vecs[11] = mk(0, 0, 0, 1, 0, 1, 2, 1, 0, 0, 1, 6, 0);
    vecs[12] = mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 6, 0);
    vecs[13] = mk(0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 1, 6, 0);
    vecs[14] = mk(0, 0, 0, 1, 2, 1, 0, 1, 1, 0, 1, 6, 0);
    vecs[15] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 6, 0);
    vecs[16] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 6, 0);
    vecs[17] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 6, 0);
    vecs[18] = mk(0, 1, 7, 0, 0, 0, 0, 0, 0, 1, 1, 6, 0);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 0);
    vecs[20] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0);
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    #2;
    check("reset_we", int'(mem_we), 0);
    check("reset_total", int'(total_health), 0);
    check("reset_done", int'(init_done), 0);
    check("reset_ready", int'(hit_ready), 0);

    @(negedge clk);
    resetn = 1'b1;
    gw_cnt = 0;

    for (int i = 0; i < 22; i++) begin
      logic ok;
      @(negedge clk);
      level_start = vecs[i].start;
      hit_valid   = vecs[i].hv;
      hit_idx     = vecs[i].hidx;
      #1;
      ok = (mem_we == vecs[i].we) && (game_write == vecs[i].gw) &&
           (brick_destroyed == vecs[i].bd) && (hit_ready == vecs[i].hr) &&
           (init_done == vecs[i].done) && (total_health == vecs[i].tot) &&
           (level_addr == vecs[i].laddr) &&
           (!vecs[i].acare || mem_addr == vecs[i].addr) &&
           (!vecs[i].we || mem_wdata == vecs[i].wdata);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display({"FAIL vec%0d: got we=%0d addr=%0d wd=%0d gw=%0d bd=%0d rdy=%0d done=%0d ",
                  "tot=%0d la=%0d; expected we=%0d addr=%0d wd=%0d gw=%0d bd=%0d rdy=%0d ",
                  "done=%0d tot=%0d la=%0d"},
                 i, mem_we, mem_addr, mem_wdata, game_write, brick_destroyed, hit_ready,
                 init_done, total_health, level_addr, vecs[i].we, vecs[i].addr,
                 vecs[i].wdata, vecs[i].gw, vecs[i].bd, vecs[i].hr, vecs[i].done,
                 vecs[i].tot, vecs[i].laddr);
      end
    end
    level_start = 1'b0;
    hit_valid   = 1'b0;
    check("game_write_pulses", gw_cnt, 2);
    check("ram0_after_hit", int'(ram[0]), 2);
    check("ram2_after_hit", int'(ram[2]), 0);

    // Let the second load run part-way, then reset it asynchronously.
    repeat (3) @(negedge clk);
    #1;
    check("midload_total_before_reset", int'(total_health), 3);
    check("midload_we_before_reset", int'(mem_we), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("midload_reset_we", int'(mem_we), 0);
    check("midload_reset_total", int'(total_health), 0);
    check("midload_reset_laddr", int'(level_addr), 0);
    check("midload_reset_done", int'(init_done), 0);

    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) ram[i] = 7;
    @(negedge clk);
    check("idle_after_reset_we", int'(mem_we), 0);
    wr_cnt = 0;
    level_start = 1'b1;
    @(negedge clk);
    level_start = 1'b0;
    begin
      int k;
      k = 0;
      while (!init_done && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("reload_done", int'(init_done), 1);
      check("reload_cycles", k, 8);
    end
    check("reload_total", int'(total_health), 6);
    check("reload_writes", wr_cnt, 4);
    for (int i = 0; i < 4; i++) check($sformatf("reload_ram%0d", i), int'(ram[i]), int'(rom[i]));
    check("reload_ready", int'(hit_ready), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
